// File: rtl/clock_input_conditioner.sv
// Board input front end: synchronises, debounces and edge-detects KEY1/SW0..SW2
// and flags illegal multi-adjust switch settings.
module clock_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic DispWeek_n_Raw,
    input  logic AdjtWeek_Raw,
    input  logic AdjtMin_Raw,
    input  logic AdjtHour_Raw,
    output logic DispWeek_n,
    output logic DispWeek_Press,
    output logic AdjtWeek,
    output logic AdjtMin,
    output logic AdjtHour,
    output logic AdjtWeek_Rise,
    output logic AdjtMin_Rise,
    output logic AdjtHour_Rise,
    output logic Adjt_Conflict
);

    // Channel order: [0] DispWeek_n (idle high), [1] AdjtWeek, [2] AdjtMin, [3] AdjtHour
    localparam logic [3:0]       IDLE_LVL = 4'b0001;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       rawIn;
    logic [3:0]       syncS1;
    logic [3:0]       syncS2;
    logic [3:0]       stable;
    logic [3:0]       edgePulse;
    logic [CNT_W-1:0] cnt [4];
    logic             conflict;

    assign rawIn = {AdjtHour_Raw, AdjtMin_Raw, AdjtWeek_Raw, DispWeek_n_Raw};

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            syncS1    <= IDLE_LVL;
            syncS2    <= IDLE_LVL;
            stable    <= IDLE_LVL;
            edgePulse <= '0;
            conflict  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            syncS1 <= rawIn;
            syncS2 <= syncS1;
            for (int i = 0; i < 4; i++) begin
                edgePulse[i] <= 1'b0;
                if (syncS2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_LAST) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else begin
                    stable[i]    <= syncS2[i];
                    cnt[i]       <= '0;
                    // Pulse only on the move away from idle: press for KEY1, rise for switches.
                    edgePulse[i] <= (syncS2[i] != IDLE_LVL[i]);
                end
            end
            conflict <= (stable[1] & stable[2]) | (stable[1] & stable[3]) | (stable[2] & stable[3]);
        end
    end

    assign DispWeek_n     = stable[0];
    assign AdjtWeek       = stable[1];
    assign AdjtMin        = stable[2];
    assign AdjtHour       = stable[3];
    assign DispWeek_Press = edgePulse[0];
    assign AdjtWeek_Rise  = edgePulse[1];
    assign AdjtMin_Rise   = edgePulse[2];
    assign AdjtHour_Rise  = edgePulse[3];
    assign Adjt_Conflict  = conflict;

endmodule

// File: tb/tb_clock_input_conditioner.sv
// Bench for clock_input_conditioner: directed scenarios plus randomized toggling,
// checked every cycle against a sample-window reference model.
module tb_clock_input_conditioner;

    localparam int         D    = 8;
    localparam logic [3:0] IDLE = 4'b0001;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic DispWeek_n_Raw = 1'b1;
    logic AdjtWeek_Raw = 1'b0;
    logic AdjtMin_Raw = 1'b0;
    logic AdjtHour_Raw = 1'b0;
    logic DispWeek_n, DispWeek_Press, AdjtWeek, AdjtMin, AdjtHour;
    logic AdjtWeek_Rise, AdjtMin_Rise, AdjtHour_Rise, Adjt_Conflict;

    clock_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .DispWeek_n_Raw(DispWeek_n_Raw),
        .AdjtWeek_Raw(AdjtWeek_Raw),
        .AdjtMin_Raw(AdjtMin_Raw),
        .AdjtHour_Raw(AdjtHour_Raw),
        .DispWeek_n(DispWeek_n),
        .DispWeek_Press(DispWeek_Press),
        .AdjtWeek(AdjtWeek),
        .AdjtMin(AdjtMin),
        .AdjtHour(AdjtHour),
        .AdjtWeek_Rise(AdjtWeek_Rise),
        .AdjtMin_Rise(AdjtMin_Rise),
        .AdjtHour_Rise(AdjtHour_Rise),
        .Adjt_Conflict(Adjt_Conflict)
    );

    always #10 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a clean level flips once the last D synchronised samples
    // (raw samples taken two edges earlier) all disagree with it.
    logic [3:0] hist[$];
    logic [3:0] mClean = IDLE;
    logic [3:0] mPulse = 4'b0000;
    logic       mConf  = 1'b0;
    logic [3:0] mRaw;
    logic       mNewConf;
    logic       allDiff;
    int         n;

    always @(posedge CLK) begin
        if (!RSTn) begin
            if (hist.size() > 0) hist[hist.size()-1] = IDLE;
            hist.push_back(IDLE);
            mClean = IDLE;
            mPulse = 4'b0000;
            mConf  = 1'b0;
        end else begin
            mRaw = {AdjtHour_Raw, AdjtMin_Raw, AdjtWeek_Raw, DispWeek_n_Raw};
            hist.push_back(mRaw);
            n = hist.size() - 1;
            mNewConf = ((int'(mClean[1]) + int'(mClean[2]) + int'(mClean[3])) >= 2);
            mPulse = 4'b0000;
            if (n >= D + 1) begin
                for (int ch = 0; ch < 4; ch++) begin
                    allDiff = 1'b1;
                    for (int k = n - D - 1; k <= n - 2; k++) begin
                        if (hist[k][ch] == mClean[ch]) allDiff = 1'b0;
                    end
                    if (allDiff) begin
                        mClean[ch] = ~mClean[ch];
                        mPulse[ch] = (mClean[ch] != IDLE[ch]);
                    end
                end
            end
            mConf = mNewConf;
        end
    end

    always @(negedge CLK) begin
        checkVal("m_DispWeek_n", DispWeek_n, mClean[0]);
        checkVal("m_AdjtWeek", AdjtWeek, mClean[1]);
        checkVal("m_AdjtMin", AdjtMin, mClean[2]);
        checkVal("m_AdjtHour", AdjtHour, mClean[3]);
        checkVal("m_Press", DispWeek_Press, mPulse[0]);
        checkVal("m_WeekRise", AdjtWeek_Rise, mPulse[1]);
        checkVal("m_MinRise", AdjtMin_Rise, mPulse[2]);
        checkVal("m_HourRise", AdjtHour_Rise, mPulse[3]);
        checkVal("m_Conflict", Adjt_Conflict, mConf);
    end

    task automatic checkResetOuts(input string tag);
        checkVal({tag, "_levels"}, {DispWeek_n, AdjtWeek, AdjtMin, AdjtHour}, 4'b1000);
        checkVal({tag, "_pulses"}, {DispWeek_Press, AdjtWeek_Rise, AdjtMin_Rise, AdjtHour_Rise}, 4'b0000);
        checkVal({tag, "_conflict"}, Adjt_Conflict, 0);
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, lows, r, hRise, cRise, wFall, cFall, togDen;

        // Reset and clean step on AdjtMin
        RSTn = 1'b0;
        cycles(3);
        checkResetOuts("reset");
        RSTn = 1'b1;
        AdjtMin_Raw = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(negedge CLK);
            if (e < 10) checkVal("step_min_early", AdjtMin, 0);
            if (e == 10) begin
                checkVal("step_min_level", AdjtMin, 1);
                checkVal("step_min_rise", AdjtMin_Rise, 1);
            end
            if (e == 11) checkVal("step_min_rise_off", AdjtMin_Rise, 0);
            checkVal("step_conflict", Adjt_Conflict, 0);
        end
        AdjtMin_Raw = 1'b0;
        cycles(20);

        // Bounce rejection on KEY1
        p = 0; lows = 0;
        DispWeek_n_Raw = 1'b0;
        repeat (5) begin @(negedge CLK); p += int'(DispWeek_Press); lows += int'(!DispWeek_n); end
        DispWeek_n_Raw = 1'b1;
        repeat (2) begin @(negedge CLK); p += int'(DispWeek_Press); lows += int'(!DispWeek_n); end
        DispWeek_n_Raw = 1'b0;
        repeat (6) begin @(negedge CLK); p += int'(DispWeek_Press); lows += int'(!DispWeek_n); end
        DispWeek_n_Raw = 1'b1;
        repeat (15) begin @(negedge CLK); p += int'(DispWeek_Press); lows += int'(!DispWeek_n); end
        checkVal("bounce_press", p, 0);
        checkVal("bounce_level", lows, 0);

        p = 0;
        DispWeek_n_Raw = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge CLK);
            p += int'(DispWeek_Press);
            if (e == 9) checkVal("press_level_early", DispWeek_n, 1);
            if (e == 10) begin
                checkVal("press_level", DispWeek_n, 0);
                checkVal("press_pulse", DispWeek_Press, 1);
            end
        end
        checkVal("press_count", p, 1);

        p = 0;
        DispWeek_n_Raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge CLK);
            p += int'(DispWeek_Press);
            if (e == 9) checkVal("release_level_early", DispWeek_n, 0);
            if (e == 10) checkVal("release_level", DispWeek_n, 1);
        end
        checkVal("release_press_count", p, 0);

        // Conflict
        AdjtWeek_Raw = 1'b1;
        cycles(30);
        AdjtHour_Raw = 1'b1;
        hRise = -1; cRise = -1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge CLK);
            if (AdjtHour && hRise < 0) hRise = e;
            if (Adjt_Conflict && cRise < 0) cRise = e;
        end
        checkVal("conf_hour_rise_edge", hRise, 10);
        checkVal("conf_rise_edge", cRise, 11);
        AdjtWeek_Raw = 1'b0;
        wFall = -1; cFall = -1; r = 0;
        for (int e = 1; e <= 40; e++) begin
            @(negedge CLK);
            r += int'(AdjtWeek_Rise | AdjtMin_Rise | AdjtHour_Rise);
            if (!AdjtWeek && wFall < 0) wFall = e;
            if (!Adjt_Conflict && cFall < 0) cFall = e;
        end
        checkVal("conf_week_fall_edge", wFall, 10);
        checkVal("conf_fall_edge", cFall, 11);
        checkVal("conf_fall_rises", r, 0);
        AdjtHour_Raw = 1'b0;
        cycles(20);

        // Simultaneous switch steps
        AdjtWeek_Raw = 1'b1; AdjtMin_Raw = 1'b1; AdjtHour_Raw = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(negedge CLK);
            if (e == 9) checkVal("simul_rise_early", {AdjtHour_Rise, AdjtMin_Rise, AdjtWeek_Rise}, 3'b000);
            if (e == 10) begin
                checkVal("simul_rise", {AdjtHour_Rise, AdjtMin_Rise, AdjtWeek_Rise}, 3'b111);
                checkVal("simul_conf_early", Adjt_Conflict, 0);
            end
            if (e == 11) begin
                checkVal("simul_conf", Adjt_Conflict, 1);
                checkVal("simul_rise_off", {AdjtHour_Rise, AdjtMin_Rise, AdjtWeek_Rise}, 3'b000);
            end
        end
        AdjtWeek_Raw = 1'b0; AdjtMin_Raw = 1'b0; AdjtHour_Raw = 1'b0;
        cycles(20);

        // Reset in the middle of a count
        AdjtHour_Raw = 1'b1;
        cycles(7);
        RSTn = 1'b0;
        cycles(2);
        checkResetOuts("midreset");
        RSTn = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(negedge CLK);
            if (e <= 9) begin
                checkVal("midreset_hour_early", AdjtHour, 0);
                checkVal("midreset_rise_early", AdjtHour_Rise, 0);
            end
            if (e == 10) begin
                checkVal("midreset_hour", AdjtHour, 1);
                checkVal("midreset_rise", AdjtHour_Rise, 1);
            end
            if (e == 11) checkVal("midreset_rise_off", AdjtHour_Rise, 0);
        end
        AdjtHour_Raw = 1'b0;
        cycles(20);

        // Randomized toggling, alternating bouncy and calm segments, occasional reset
        togDen = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) togDen = ($urandom_range(0, 1) == 0) ? 3 : 20;
            if (!RSTn) begin
                if ($urandom_range(0, 1) == 0) RSTn = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                RSTn = 1'b0;
            end
            if ($urandom_range(0, togDen - 1) == 0) DispWeek_n_Raw = ~DispWeek_n_Raw;
            if ($urandom_range(0, togDen - 1) == 0) AdjtWeek_Raw = ~AdjtWeek_Raw;
            if ($urandom_range(0, togDen - 1) == 0) AdjtMin_Raw = ~AdjtMin_Raw;
            if ($urandom_range(0, togDen - 1) == 0) AdjtHour_Raw = ~AdjtHour_Raw;
            @(negedge CLK);
        end
        RSTn = 1'b1;
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_input_conditioner.md
Name: clock_input_conditioner

Overview:
- Upstream stage of the digital clock top. Sits between the board's raw KEY1/SW0/SW1/SW2 pins and the timekeeper/display blocks.
- Per channel: synchronises to CLK, debounces, and outputs a clean level plus one-cycle edge pulses.
- Also flags an illegal multi-adjust switch setting.
- Outputs DispWeek_n, AdjtWeek, AdjtHour and AdjtMin connect directly to the existing same-named inputs of the timekeeper and display blocks.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, stable-input cycles required before a clean level changes (20 ms at 50 MHz); legal range 2..2^20-1.
- CNT_W, 20, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock, 50 MHz
- RSTn  input  1  synchronous active-low reset (KEY0); all state is sampled on CLK rising edge
- DispWeek_n_Raw  input  1  raw KEY1, active-low push button
- AdjtWeek_Raw  input  1  raw SW0
- AdjtMin_Raw  input  1  raw SW1
- AdjtHour_Raw  input  1  raw SW2
- DispWeek_n  output  1  debounced KEY1 level, active-low
- DispWeek_Press  output  1  one-cycle pulse on clean 1->0 of DispWeek_n
- AdjtWeek  output  1  debounced SW0 level
- AdjtMin  output  1  debounced SW1 level
- AdjtHour  output  1  debounced SW2 level
- AdjtWeek_Rise  output  1  one-cycle pulse on clean 0->1 of AdjtWeek
- AdjtMin_Rise  output  1  one-cycle pulse on clean 0->1 of AdjtMin
- AdjtHour_Rise  output  1  one-cycle pulse on clean 0->1 of AdjtHour
- Adjt_Conflict  output  1  high while two or more clean adjust levels are high

Behaviour:
- Reset is synchronous and active-low: while RSTn=0 at a CLK edge, all registers take reset values.
- Reset values:
  - Sync flops and clean levels take the inactive level: DispWeek_n path=1; AdjtWeek/AdjtMin/AdjtHour paths=0.
  - Counters=0; all pulse outputs=0; Adjt_Conflict=0.
- Synchroniser: 2-flop chain per channel (s1, s2). Raw inputs are never used past s1.
- Debounce, per channel, with registers stable and cnt[CNT_W-1:0]:
  - s2==stable: cnt<=0.
  - s2!=stable and cnt!=DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s2, cnt<=0, edge pulse asserted this same cycle.
- Latency: take edge 1 as the first edge that samples a new raw level. That level must hold, and the clean output changes at edge DEBOUNCE_CYCLES+2. Each pulse is registered, high exactly that one cycle.
- Glitch rejection: any return of s2 to stable before the count completes clears cnt. A bounce shorter than DEBOUNCE_CYCLES cycles produces no level change and no pulse.
- Pulse polarity:
  - DispWeek_Press fires only on the clean falling edge (press), never on release.
  - Adjt*_Rise fire only on the clean rising edge.
- Adjt_Conflict: registered, updated every cycle from the clean levels of the current cycle, so it lags them by 1 cycle. Asserted when popcount(AdjtWeek, AdjtMin, AdjtHour) >= 2. Downstream blocks ignore adjust while it is high; this block does not mask the levels.
- Channels are fully independent. Simultaneous transitions on several inputs debounce in parallel; their pulses may coincide.
- Reset mid-count:
  - Counter is discarded; stable returns to its inactive level.
  - After release, an input still held at its active level is debounced from scratch: it changes stable and fires its pulse at edge DEBOUNCE_CYCLES+2, counted from the first sampling edge after RSTn=1.
- Counter never wraps: the max reachable value is DEBOUNCE_CYCLES-1.

Test Plan:
- DEBOUNCE_CYCLES=8 for all tests.
- Reset & clean step: hold RSTn=0 for 3 cycles, check all outputs at reset values. Release, step AdjtMin_Raw 0->1 and hold. AdjtMin=1 and AdjtMin_Rise=1 for exactly 1 cycle at edge 10 after first sample. Adjt_Conflict stays 0.
- Bounce rejection: toggle DispWeek_n_Raw 1->0 for 5 cycles, ->1 for 2, ->0 for 6, then back to 1. DispWeek_n stays 1 and DispWeek_Press never fires. Then hold 0 for 20 cycles: one Press pulse, and DispWeek_n=0 at edge 10. Release: DispWeek_n returns to 1 with no pulse.
- Conflict: set AdjtWeek_Raw=1, then AdjtHour_Raw=1 30 cycles later. Adjt_Conflict rises 1 cycle after the clean AdjtHour rises. Clear AdjtWeek_Raw: Adjt_Conflict falls 1 cycle after the clean AdjtWeek falls. No Rise pulse fires on the fall.
- Simultaneous: step all three switch raws 0->1 on the same edge. All three Rise pulses fire on the same cycle (edge 10). Adjt_Conflict=1 from edge 11.
- Reset mid-operation: AdjtHour_Raw=1, assert RSTn=0 at cnt=5. Outputs return to reset values. Keep AdjtHour_Raw=1 and release reset: AdjtHour rises and Rise pulses at edge 10 after release, not earlier.
